// File: rtl/ccr_unit_pkg.sv
// Shared definitions for the condition-code register: flag update modes,
// 68k condition codes and CCR bit positions.
package ccr_unit_pkg;

   typedef enum logic [1:0] {
      MODE_ARITH  = 2'b00,
      MODE_LOGIC  = 2'b01,
      MODE_EXTEND = 2'b10,
      MODE_CMP    = 2'b11
   } flag_mode_e;

   typedef enum logic [3:0] {
      COND_T  = 4'd0,
      COND_F  = 4'd1,
      COND_HI = 4'd2,
      COND_LS = 4'd3,
      COND_CC = 4'd4,
      COND_CS = 4'd5,
      COND_NE = 4'd6,
      COND_EQ = 4'd7,
      COND_VC = 4'd8,
      COND_VS = 4'd9,
      COND_PL = 4'd10,
      COND_MI = 4'd11,
      COND_GE = 4'd12,
      COND_LT = 4'd13,
      COND_GT = 4'd14,
      COND_LE = 4'd15
   } cond_e;

   localparam int unsigned CCR_X = 4;
   localparam int unsigned CCR_N = 3;
   localparam int unsigned CCR_Z = 2;
   localparam int unsigned CCR_V = 1;
   localparam int unsigned CCR_C = 0;

   // Next CCR value for an ALU-driven update; EXTEND keeps Z sticky so
   // multi-precision ADDX/SUBX chains report zero only if every word was zero.
   function automatic logic [4:0] ccr_update(input logic [4:0]  ccr_old,
                                             input flag_mode_e  mode,
                                             input logic        c,
                                             input logic        z,
                                             input logic        v,
                                             input logic        n);
      logic [4:0] r;
      r = ccr_old;
      case (mode)
         MODE_ARITH: begin
            r[CCR_X] = c;
            r[CCR_N] = n;
            r[CCR_Z] = z;
            r[CCR_V] = v;
            r[CCR_C] = c;
         end
         MODE_LOGIC: begin
            r[CCR_N] = n;
            r[CCR_Z] = z;
            r[CCR_V] = 1'b0;
            r[CCR_C] = 1'b0;
         end
         MODE_EXTEND: begin
            r[CCR_X] = c;
            r[CCR_N] = n;
            r[CCR_Z] = ccr_old[CCR_Z] & z;
            r[CCR_V] = v;
            r[CCR_C] = c;
         end
         MODE_CMP: begin
            r[CCR_N] = n;
            r[CCR_Z] = z;
            r[CCR_V] = v;
            r[CCR_C] = c;
         end
         default: r = ccr_old;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ccr_unit_cond_eval.sv
// Combinational 68k condition evaluator; shared by Bcc/DBcc here and by the
// Scc/TRAPcc decode elsewhere.
module cond_eval
   import ccr_unit_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [4:0] ccr_i,
   output logic       result_o
);

   logic n, z, v, c;
   logic unused_x;

   assign n        = ccr_i[CCR_N];
   assign z        = ccr_i[CCR_Z];
   assign v        = ccr_i[CCR_V];
   assign c        = ccr_i[CCR_C];
   assign unused_x = ccr_i[CCR_X];

   always_comb begin
      result_o = 1'b0;
      case (cond_e'(cond_i))
         COND_T:  result_o = 1'b1;
         COND_F:  result_o = 1'b0;
         COND_HI: result_o = ~c & ~z;
         COND_LS: result_o = c | z;
         COND_CC: result_o = ~c;
         COND_CS: result_o = c;
         COND_NE: result_o = ~z;
         COND_EQ: result_o = z;
         COND_VC: result_o = ~v;
         COND_VS: result_o = v;
         COND_PL: result_o = ~n;
         COND_MI: result_o = n;
         COND_GE: result_o = n ~^ v;
         COND_LT: result_o = n ^ v;
         COND_GT: result_o = ~z & (n ~^ v);
         COND_LE: result_o = z | (n ^ v);
         default: result_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register with ALU flag capture, X carry-in feedback and a
// registered Bcc/DBcc branch decision.
module ccr_unit
   import ccr_unit_pkg::*;
#(
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                alu_C,
   input  logic                alu_Z,
   input  logic                alu_V,
   input  logic                alu_N,
   input  logic                flag_we,
   input  logic [1:0]          flag_mode,
   input  logic                ccr_we,
   input  logic [4:0]          ccr_din,
   input  logic                cond_valid,
   input  logic [3:0]          cond,
   input  logic                dbcc,
   input  logic [CNT_BITS-1:0] cnt_in,
   output logic                X,
   output logic [4:0]          ccr,
   output logic                res_valid,
   output logic                cond_true,
   output logic                taken,
   output logic [CNT_BITS-1:0] cnt_out
);

   logic [4:0]          ccr_q, ccr_d;
   logic                res_valid_q;
   logic                cond_true_q, cond_true_d;
   logic                taken_q, taken_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic                eval;
   logic [CNT_BITS-1:0] cnt_dec;

   // Evaluation reads ccr_q, so a same-cycle flag update is not visible.
   cond_eval u_cond_eval (
      .cond_i   (cond),
      .ccr_i    (ccr_q),
      .result_o (eval)
   );

   always_comb begin
      ccr_d = ccr_q;
      if (ccr_we) begin
         ccr_d = ccr_din;
      end else if (flag_we) begin
         ccr_d = ccr_update(ccr_q, flag_mode_e'(flag_mode),
                            alu_C, alu_Z, alu_V, alu_N);
      end
   end

   assign cnt_dec = cnt_in - CNT_BITS'(1);

   always_comb begin
      cond_true_d = eval;
      taken_d     = eval;
      cnt_d       = cnt_in;
      if (dbcc && !eval) begin
         cnt_d   = cnt_dec;
         taken_d = (cnt_dec != '1);
      end else if (dbcc) begin
         taken_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ccr_q <= '0;
      end else begin
         ccr_q <= ccr_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_valid_q <= 1'b0;
         cond_true_q <= 1'b0;
         taken_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         res_valid_q <= cond_valid;
         if (cond_valid) begin
            cond_true_q <= cond_true_d;
            taken_q     <= taken_d;
            cnt_q       <= cnt_d;
         end
      end
   end

   assign ccr       = ccr_q;
   assign X         = ccr_q[CCR_X];
   assign res_valid = res_valid_q;
   assign cond_true = cond_true_q;
   assign taken     = taken_q;
   assign cnt_out   = cnt_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: CCR tracked by a reference model, branch
// results queued at request time and matched when res_valid appears.
module tb_ccr_unit;

   localparam int unsigned CNT_BITS = 16;

   logic                clk;
   logic                reset_n;
   logic                alu_C, alu_Z, alu_V, alu_N;
   logic                flag_we;
   logic [1:0]          flag_mode;
   logic                ccr_we;
   logic [4:0]          ccr_din;
   logic                cond_valid;
   logic [3:0]          cond;
   logic                dbcc;
   logic [CNT_BITS-1:0] cnt_in;
   logic                X;
   logic [4:0]          ccr;
   logic                res_valid;
   logic                cond_true;
   logic                taken;
   logic [CNT_BITS-1:0] cnt_out;

   ccr_unit #(.CNT_BITS(CNT_BITS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .alu_C      (alu_C),
      .alu_Z      (alu_Z),
      .alu_V      (alu_V),
      .alu_N      (alu_N),
      .flag_we    (flag_we),
      .flag_mode  (flag_mode),
      .ccr_we     (ccr_we),
      .ccr_din    (ccr_din),
      .cond_valid (cond_valid),
      .cond       (cond),
      .dbcc       (dbcc),
      .cnt_in     (cnt_in),
      .X          (X),
      .ccr        (ccr),
      .res_valid  (res_valid),
      .cond_true  (cond_true),
      .taken      (taken),
      .cnt_out    (cnt_out)
   );

   typedef struct {
      logic                ct;
      logic                tk;
      logic [CNT_BITS-1:0] cnt;
      int                  due;
   } exp_t;

   exp_t                sb[$];
   int                  n_checks = 0;
   int                  n_errors = 0;
   int                  cyc = 0;
   logic [4:0]          m_ccr;
   logic                last_ct, last_tk;
   logic [CNT_BITS-1:0] last_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic ref_eval(input logic [3:0] cc, input logic [4:0] r);
      logic n, z, v, c;
      n = r[3]; z = r[2]; v = r[1]; c = r[0];
      case (cc)
         4'd0:  return 1'b1;
         4'd1:  return 1'b0;
         4'd2:  return !(c || z);
         4'd3:  return c || z;
         4'd4:  return !c;
         4'd5:  return c;
         4'd6:  return !z;
         4'd7:  return z;
         4'd8:  return !v;
         4'd9:  return v;
         4'd10: return !n;
         4'd11: return n;
         4'd12: return n == v;
         4'd13: return n != v;
         4'd14: return !z && (n == v);
         default: return z || (n != v);
      endcase
   endfunction

   // Result monitor: sampled on the falling edge, away from register updates.
   always @(negedge clk) begin
      if (reset_n) begin
         if (res_valid) begin
            if (sb.size() == 0) begin
               check("spurious_res_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("latency", cyc, e.due);
               check("cond_true", cond_true, e.ct);
               check("taken", taken, e.tk);
               check("cnt_out", cnt_out, e.cnt);
               last_ct  = e.ct;
               last_tk  = e.tk;
               last_cnt = e.cnt;
            end
         end else begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
               check("missing_res_valid", 32'd0, 32'd1);
               void'(sb.pop_front());
            end
            check("hold_cond_true", cond_true, last_ct);
            check("hold_taken", taken, last_tk);
            check("hold_cnt_out", cnt_out, last_cnt);
         end
      end
   end

   task automatic idle_inputs();
      alu_C = 0; alu_Z = 0; alu_V = 0; alu_N = 0;
      flag_we = 0; flag_mode = 2'b00; ccr_we = 0; ccr_din = '0;
      cond_valid = 0; cond = 4'd0; dbcc = 0; cnt_in = '0;
   endtask

   // Called at a falling edge with inputs set; advances one cycle.
   task automatic step();
      exp_t e;
      logic ev;
      if (cond_valid) begin
         ev = ref_eval(cond, m_ccr);
         e.ct  = ev;
         e.tk  = ev;
         e.cnt = cnt_in;
         if (dbcc) begin
            if (ev) begin
               e.tk = 1'b0;
            end else begin
               e.cnt = cnt_in - 16'd1;
               e.tk  = (e.cnt != 16'hFFFF);
            end
         end
         e.due = cyc + 1;
         sb.push_back(e);
      end
      if (ccr_we) begin
         m_ccr = ccr_din;
      end else if (flag_we) begin
         case (flag_mode)
            2'b00: m_ccr = {alu_C, alu_N, alu_Z, alu_V, alu_C};
            2'b01: m_ccr = {m_ccr[4], alu_N, alu_Z, 1'b0, 1'b0};
            2'b10: m_ccr = {alu_C, alu_N, m_ccr[2] & alu_Z, alu_V, alu_C};
            default: m_ccr = {m_ccr[4], alu_N, alu_Z, alu_V, alu_C};
         endcase
      end
      @(posedge clk);
      @(negedge clk);
      check("ccr", ccr, m_ccr);
      check("X", X, m_ccr[4]);
      idle_inputs();
   endtask

   task automatic flags(input logic [1:0] mode, input logic c, z, v, n);
      flag_we = 1; flag_mode = mode;
      alu_C = c; alu_Z = z; alu_V = v; alu_N = n;
      step();
   endtask

   task automatic load(input logic [4:0] d);
      ccr_we = 1; ccr_din = d;
      step();
   endtask

   task automatic req(input logic [3:0] cc, input logic db, input logic [15:0] cnt);
      cond_valid = 1; cond = cc; dbcc = db; cnt_in = cnt;
      step();
   endtask

   initial begin
      idle_inputs();
      reset_n  = 0;
      m_ccr    = '0;
      last_ct  = 0;
      last_tk  = 0;
      last_cnt = '0;
      @(negedge clk);
      check("rst_ccr", ccr, 5'd0);
      check("rst_X", X, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_cond_true", cond_true, 1'b0);
      check("rst_taken", taken, 1'b0);
      check("rst_cnt_out", cnt_out, 16'd0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);

      flags(2'b00, 1, 0, 0, 1);
      check("arith_ccr", ccr, 5'b11001);
      check("arith_X", X, 1'b1);

      load(5'b00100);
      flags(2'b10, 0, 1, 0, 0);
      check("ext_z_sticky1", ccr[2], 1'b1);
      flags(2'b10, 0, 0, 0, 0);
      check("ext_z_clear", ccr[2], 1'b0);
      flags(2'b10, 0, 1, 0, 0);
      check("ext_z_stays0", ccr[2], 1'b0);

      flags(2'b00, 1, 0, 0, 0);
      flags(2'b01, 1, 0, 1, 0);
      check("logic_ccr", ccr, 5'b10000);
      ccr_we = 1; ccr_din = 5'b00011;
      flags(2'b00, 0, 1, 0, 1);
      check("ccr_we_priority", ccr, 5'b00011);
      flags(2'b11, 1, 1, 1, 0);
      check("cmp_ccr", ccr, 5'b00111);

      // Back-to-back Bcc sweep on N=1,V=1.
      load(5'b01010);
      for (int i = 0; i < 16; i++) begin
         cond_valid = 1; cond = 4'(i); dbcc = 0; cnt_in = 16'(i * 7);
         step();
      end

      load(5'b00000);
      req(4'd1, 1, 16'd3);
      check("dbf_cnt3", cnt_out, 16'd2);
      check("dbf_taken3", taken, 1'b1);
      req(4'd1, 1, 16'd0);
      check("dbf_wrap", cnt_out, 16'hFFFF);
      check("dbf_wrap_taken", taken, 1'b0);
      req(4'd0, 1, 16'd5);
      check("dbt_cnt", cnt_out, 16'd5);
      check("dbt_taken", taken, 1'b0);
      check("dbt_true", cond_true, 1'b1);
      req(4'd1, 1, 16'd1);
      check("dbf_to_zero_taken", taken, 1'b1);

      // Same-cycle hazard: EQ sees old Z=0 despite update to Z=1.
      cond_valid = 1; cond = 4'd7; dbcc = 0; cnt_in = 16'd9;
      flags(2'b00, 0, 1, 0, 0);
      check("hazard_eq", cond_true, 1'b0);
      check("hazard_ccr_z", ccr[2], 1'b1);

      for (int i = 0; i < 60; i++) begin
         ccr_we     = ($urandom_range(0, 5) == 0);
         ccr_din    = 5'($urandom);
         flag_we    = ($urandom_range(0, 1) == 1);
         flag_mode  = 2'($urandom);
         {alu_C, alu_Z, alu_V, alu_N} = 4'($urandom);
         cond_valid = ($urandom_range(0, 9) < 7);
         cond       = 4'($urandom);
         dbcc       = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0: cnt_in = 16'd0;
            1: cnt_in = 16'd1;
            2: cnt_in = 16'hFFFF;
            default: cnt_in = 16'($urandom);
         endcase
         step();
      end

      // Reset during a pending evaluation: no result may emerge.
      load(5'b11111);
      cond_valid = 1; cond = 4'd0; dbcc = 0; cnt_in = 16'd4;
      #2 reset_n = 0;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      m_ccr = '0; last_ct = 0; last_tk = 0; last_cnt = '0;
      check("abort_res_valid", res_valid, 1'b0);
      check("abort_ccr", ccr, 5'd0);
      @(negedge clk);
      check("abort_res_valid2", res_valid, 1'b0);
      reset_n = 1;
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
